// File: rtl/dff_bank_rr_sched.sv
// Round-robin toggle scheduler over a bank of N single-bit registers.
// One toggle is granted per clock; a parallel load overrides scheduling.
module dff_bank_rr_sched #(
   parameter int N = 4,
   parameter logic [N-1:0] INIT = N'(4'b0010),
   parameter int CW = 8,
   localparam int PW = (N > 2) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          load_en,
   input  logic [N-1:0]  load_data,
   output logic [N-1:0]  gnt,
   output logic [N-1:0]  q,
   output logic [N-1:0]  q_inv,
   output logic [PW-1:0] ptr,
   output logic [CW-1:0] toggle_cnt
);

   localparam logic [PW:0] L_N = (PW+1)'(N);
   localparam logic [PW-1:0] L_LAST = PW'(N-1);

   logic [N-1:0]   r_q;
   logic [N-1:0]   r_gnt;
   logic [PW-1:0]  r_ptr;
   logic [CW-1:0]  r_cnt;

   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;
   logic [PW-1:0]  w_off;
   logic [PW:0]    w_sum;
   logic [PW-1:0]  w_win;
   logic [PW-1:0]  w_ptr_nxt;
   logic [N-1:0]   w_onehot;
   logic           w_any;

   // Rotate requests so bit 0 is the current priority holder.
   assign w_dbl = {req, req};
   assign w_rot = N'(w_dbl >> r_ptr);
   assign w_any = |req;

   always_comb begin
      w_off = '0;
      for (int j = N-1; j >= 0; j--) begin
         if (w_rot[j]) w_off = PW'(j);
      end
   end

   assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_win     = (w_sum >= L_N) ? PW'(w_sum - L_N) : w_sum[PW-1:0];
   assign w_ptr_nxt = (w_win == L_LAST) ? '0 : w_win + PW'(1);
   assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= INIT;
         r_gnt <= '0;
         r_ptr <= '0;
         r_cnt <= '0;
      end else if (load_en) begin
         r_q   <= load_data;
         r_gnt <= '0;
      end else if (w_any) begin
         r_q   <= r_q ^ w_onehot;
         r_gnt <= w_onehot;
         r_ptr <= w_ptr_nxt;
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_gnt <= '0;
      end
   end

   assign gnt        = r_gnt;
   assign q          = r_q;
   assign q_inv      = ~r_q;
   assign ptr        = r_ptr;
   assign toggle_cnt = r_cnt;

endmodule

// File: tb/tb_dff_bank_rr_sched.sv
// Bench for dff_bank_rr_sched: directed scenarios plus randomized
// traffic against a cyclic-search reference model.
module tb_dff_bank_rr_sched;

   localparam int N = 4;
   localparam int CW = 8;
   localparam logic [N-1:0] INIT = 4'b0010;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  req = '0;
   logic          load_en = 1'b0;
   logic [N-1:0]  load_data = '0;
   logic [N-1:0]  gnt;
   logic [N-1:0]  q;
   logic [N-1:0]  q_inv;
   logic [1:0]    ptr;
   logic [CW-1:0] toggle_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [N-1:0] m_q;
   logic [N-1:0] m_gnt;
   int           m_ptr;
   int           m_cnt;

   always #5 clk = ~clk;

   dff_bank_rr_sched #(.N(N), .INIT(INIT), .CW(CW)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .load_en(load_en),
      .load_data(load_data),
      .gnt(gnt),
      .q(q),
      .q_inv(q_inv),
      .ptr(ptr),
      .toggle_cnt(toggle_cnt)
   );

   task automatic model_reset();
      m_q = INIT;
      m_gnt = '0;
      m_ptr = 0;
      m_cnt = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic le,
                             input logic [N-1:0] ld);
      int win;
      if (le) begin
         m_q = ld;
         m_gnt = '0;
      end else if (r != '0) begin
         win = -1;
         for (int k = 0; k < N; k++) begin
            if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
         end
         m_q[win] = ~m_q[win];
         m_gnt = '0;
         m_gnt[win] = 1'b1;
         m_ptr = (win + 1) % N;
         m_cnt = (m_cnt + 1) % (1 << CW);
      end else begin
         m_gnt = '0;
      end
   endtask

   task automatic drive(input logic [N-1:0] r, input logic le,
                        input logic [N-1:0] ld);
      req = r;
      load_en = le;
      load_data = ld;
      @(posedge clk);
      model_step(r, le, ld);
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = '0;
      load_en = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (q !== INIT) begin
         n_err++; $display("FAIL reset_q got %b exp %b", q, INIT);
      end
      n_vec++;
      if (q_inv !== ~INIT) begin
         n_err++; $display("FAIL reset_qinv got %b exp %b", q_inv, ~INIT);
      end
      n_vec++;
      if (gnt !== 4'b0000) begin
         n_err++; $display("FAIL reset_gnt got %b exp 0000", gnt);
      end
      n_vec++;
      if (ptr !== 2'd0) begin
         n_err++; $display("FAIL reset_ptr got %0d exp 0", ptr);
      end
      n_vec++;
      if (toggle_cnt !== 8'd0) begin
         n_err++; $display("FAIL reset_cnt got %0d exp 0", toggle_cnt);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_lone();
      logic exp_b;
      for (int i = 0; i < 4; i++) begin
         drive(4'b0001, 1'b0, '0);
         exp_b = (i % 2 == 0);
         n_vec++;
         if (q[0] !== exp_b) begin
            n_err++; $display("FAIL lone_q0 c%0d got %b exp %b", i, q[0], exp_b);
         end
         n_vec++;
         if (gnt !== 4'b0001 || ptr !== 2'd1) begin
            n_err++;
            $display("FAIL lone_gnt c%0d got %b/%0d exp 0001/1", i, gnt, ptr);
         end
      end
      n_vec++;
      if (toggle_cnt !== 8'd4) begin
         n_err++; $display("FAIL lone_cnt got %0d exp 4", toggle_cnt);
      end
   endtask

   task automatic test_contention();
      logic [N-1:0] exp_g;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(4'b1111, 1'b0, '0);
         exp_g = 4'b0001 << (i % 4);
         n_vec++;
         if (gnt !== exp_g) begin
            n_err++; $display("FAIL cont_gnt c%0d got %b exp %b", i, gnt, exp_g);
         end
      end
      n_vec++;
      if (q !== INIT || ptr !== 2'd0 || toggle_cnt !== 8'd8) begin
         n_err++;
         $display("FAIL cont_end got q=%b p=%0d c=%0d exp q=%b p=0 c=8",
                  q, ptr, toggle_cnt, INIT);
      end
   endtask

   task automatic test_ptr_wrap();
      do_reset();
      drive(4'b0100, 1'b0, '0);
      n_vec++;
      if (ptr !== 2'd3) begin
         n_err++; $display("FAIL wrap_setup got ptr %0d exp 3", ptr);
      end
      drive(4'b0110, 1'b0, '0);
      n_vec++;
      if (gnt !== 4'b0010 || ptr !== 2'd2) begin
         n_err++; $display("FAIL wrap_skip got %b/%0d exp 0010/2", gnt, ptr);
      end
      drive(4'b0110, 1'b0, '0);
      n_vec++;
      if (gnt !== 4'b0100 || ptr !== 2'd3) begin
         n_err++; $display("FAIL wrap_next got %b/%0d exp 0100/3", gnt, ptr);
      end
   endtask

   task automatic test_load();
      do_reset();
      drive(4'b1111, 1'b1, 4'b1001);
      n_vec++;
      if (q !== 4'b1001 || q_inv !== 4'b0110 || gnt !== 4'b0000) begin
         n_err++;
         $display("FAIL load_q got q=%b qi=%b g=%b exp 1001/0110/0000",
                  q, q_inv, gnt);
      end
      n_vec++;
      if (ptr !== 2'd0 || toggle_cnt !== 8'd0) begin
         n_err++; $display("FAIL load_hold got p=%0d c=%0d exp 0/0", ptr, toggle_cnt);
      end
      drive(4'b1111, 1'b0, '0);
      n_vec++;
      if (gnt !== 4'b0001 || q !== 4'b1000) begin
         n_err++; $display("FAIL load_after got g=%b q=%b exp 0001/1000", gnt, q);
      end
   endtask

   task automatic test_cnt_wrap();
      logic [N-1:0] r;
      do_reset();
      for (int i = 0; i < 255; i++) begin
         r = N'($urandom_range(1, 15));
         drive(r, 1'b0, '0);
      end
      n_vec++;
      if (toggle_cnt !== 8'd255) begin
         n_err++; $display("FAIL cnt_max got %0d exp 255", toggle_cnt);
      end
      drive(4'b1000, 1'b0, '0);
      n_vec++;
      if (toggle_cnt !== 8'd0) begin
         n_err++; $display("FAIL cnt_wrap got %0d exp 0", toggle_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) drive(4'b1111, 1'b0, '0);
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (q !== INIT || q_inv !== ~INIT || gnt !== 4'b0000 || ptr !== 2'd0
          || toggle_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL rst_mid got q=%b g=%b p=%0d c=%0d", q, gnt, ptr, toggle_cnt);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(4'b1111, 1'b0, '0);
      n_vec++;
      if (gnt !== 4'b0001) begin
         n_err++; $display("FAIL rst_first got %b exp 0001", gnt);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic [N-1:0] ld;
      logic         le;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r = N'($urandom);
         le = ($urandom_range(0, 7) == 0);
         ld = N'($urandom);
         drive(r, le, ld);
         n_vec++;
         if (q !== m_q || q_inv !== ~m_q) begin
            n_err++; $display("FAIL rnd_q c%0d got %b/%b exp %b", i, q, q_inv, m_q);
         end
         n_vec++;
         if (gnt !== m_gnt || !$onehot0(gnt)) begin
            n_err++; $display("FAIL rnd_gnt c%0d got %b exp %b", i, gnt, m_gnt);
         end
         n_vec++;
         if (ptr !== 2'(m_ptr) || toggle_cnt !== 8'(m_cnt)) begin
            n_err++;
            $display("FAIL rnd_state c%0d got p=%0d c=%0d exp p=%0d c=%0d",
                     i, ptr, toggle_cnt, m_ptr, m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lone();
      test_contention();
      test_ptr_wrap();
      test_load();
      test_cnt_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
